// File: rtl/ds1302_reader_if.sv
// Bundle of request, status, display-RAM and DS1302 pin signals around ds1302_reader.
// The slave modport is the reader itself; the master modport is the surrounding logic.
interface ds1302_reader_if;
    logic       refresh;
    logic       wr_req;
    logic [2:0] wr_reg;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       busy;
    logic       valid;
    logic [3:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic       ram_we;
    logic       ds_ce;
    logic       ds_sclk;
    logic       ds_io_out;
    logic       ds_io_oe;
    logic       ds_io_in;

    modport slave (
        input  refresh, wr_req, wr_reg, wr_data, ds_io_in,
        output wr_ack, busy, valid, ram_waddr, ram_wdata, ram_we,
               ds_ce, ds_sclk, ds_io_out, ds_io_oe
    );

    modport master (
        output refresh, wr_req, wr_reg, wr_data, ds_io_in,
        input  wr_ack, busy, valid, ram_waddr, ram_wdata, ram_we,
               ds_ce, ds_sclk, ds_io_out, ds_io_oe
    );
endinterface

// File: rtl/ds1302_reader.sv
// DS1302 3-wire master: periodic burst read into display RAM, single-register writes on request.
// Latency: read CLK_DIV*146 cycles, write CLK_DIV*34 cycles; ram_we one cycle after each byte's last sample.
// Backpressure: requests stay pending while busy; write wins over read. DS1302_UNPROTECT_EN adds a WP-clear write after reset.
module ds1302_reader #(
    parameter int CLK_DIV   = 4,
    parameter int REFRESH_N = 1000
) (
    input  logic             clk,
    input  logic             clr,
    ds1302_reader_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = (REFRESH_N > 1) ? $clog2(REFRESH_N) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_RELOAD = TW'(REFRESH_N - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic          phase;
    logic [6:0]    bit_cnt;
    logic          is_read, is_internal;
    logic [15:0]   tx;
    logic [6:0]    rx;
    logic          io_q;
    logic [TW-1:0] timer;
    logic          read_pend, write_pend, unprot_pend;
    logic          ram_we_q, valid_q;
    logic [3:0]    waddr_q;
    logic [7:0]    wdata_q;
    logic          start_un, start_wr, start_rd;

    wire        div_last = (div_cnt == DIV_LAST);
    wire        last_bit = is_read ? (bit_cnt == 7'd71) : (bit_cnt == 7'd15);
    wire [2:0]  byte_idx = bit_cnt[5:3] - 3'd1;
    wire [7:0]  byte_in  = {bus.ds_io_in, rx};
    wire        ack      = (state == HOLD) && div_last && !is_read && !is_internal;

    function automatic logic [3:0] slot(input logic [2:0] k);
        case (k)
            3'd0:    slot = 4'd0;
            3'd1:    slot = 4'd1;
            3'd2:    slot = 4'd2;
            3'd3:    slot = 4'd4;
            3'd4:    slot = 4'd5;
            3'd5:    slot = 4'd3;
            3'd6:    slot = 4'd6;
            default: slot = 4'd7;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_un  = 1'b0;
        start_wr  = 1'b0;
        start_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (unprot_pend) begin
                    start_un  = 1'b1;
                    state_nxt = SETUP;
                end else if (write_pend) begin
                    start_wr  = 1'b1;
                    state_nxt = SETUP;
                end else if (read_pend) begin
                    start_rd  = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP:   if (div_last) state_nxt = SHIFT;
            SHIFT:   if (div_last && phase && last_bit) state_nxt = HOLD;
            HOLD:    if (div_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt     <= '0;
            phase       <= 1'b0;
            bit_cnt     <= '0;
            is_read     <= 1'b0;
            is_internal <= 1'b0;
            tx          <= '0;
            rx          <= '0;
            io_q        <= 1'b0;
            ram_we_q    <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            div_cnt  <= (state == IDLE || div_last) ? '0 : div_cnt + 1'b1;
            if (start_un || start_wr || start_rd) begin
                phase       <= 1'b0;
                bit_cnt     <= '0;
                is_read     <= start_rd;
                is_internal <= start_un;
                if (start_un)      tx <= {8'h00, 8'h8E};
                else if (start_wr) tx <= {bus.wr_data, 1'b1, 3'b000, bus.wr_reg, 1'b0};
                else               tx <= {8'h00, 8'hBF};
            end
            if (state == SETUP && div_last) io_q <= tx[0];
            if (state == SHIFT && div_last) begin
                phase <= ~phase;
                if (phase) begin
                    // next bit goes out as the new sclk-low phase begins
                    bit_cnt <= bit_cnt + 7'd1;
                    tx      <= {1'b0, tx[15:1]};
                    io_q    <= tx[1];
                end else if (is_read && bit_cnt >= 7'd8) begin
                    rx <= {bus.ds_io_in, rx[6:1]};
                    if (bit_cnt[2:0] == 3'd7 && byte_idx != 3'd7) begin
                        ram_we_q <= 1'b1;
                        waddr_q  <= slot(byte_idx);
                        wdata_q  <= (byte_idx == 3'd0) ? (byte_in & 8'h7F) :
                                    (byte_idx == 3'd2) ? (byte_in & 8'h3F) : byte_in;
                        if (byte_idx == 3'd6) valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            timer      <= '0;
            read_pend  <= 1'b1;
            write_pend <= 1'b0;
        end else begin
            timer <= start_rd ? T_RELOAD : ((timer != '0) ? timer - 1'b1 : timer);
            if (start_rd)                          read_pend <= 1'b0;
            else if (bus.refresh || timer == '0)   read_pend <= 1'b1;
            write_pend <= ack ? 1'b0 : bus.wr_req;
        end
    end

`ifdef DS1302_UNPROTECT_EN
    always_ff @(posedge clk) begin
        if (clr)           unprot_pend <= 1'b1;
        else if (start_un) unprot_pend <= 1'b0;
    end
`else
    assign unprot_pend = 1'b0;
`endif

    assign bus.busy      = (state != IDLE);
    assign bus.ds_ce     = (state == SETUP) || (state == SHIFT);
    assign bus.ds_sclk   = (state == SHIFT) && phase;
    // on reads the pad is released one clk after the 8th command rising edge
    assign bus.ds_io_oe  = (state == SHIFT) &&
                           (!is_read || bit_cnt < 7'd7 ||
                            (bit_cnt == 7'd7 && !(phase && div_cnt != '0)));
    assign bus.ds_io_out = io_q;
    assign bus.wr_ack    = ack;
    assign bus.valid     = valid_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_waddr = waddr_q;
    assign bus.ram_wdata = wdata_q;
endmodule

// File: tb/tb_ds1302_reader.sv
// Bench for ds1302_reader: DS1302 pin model, table of burst bytes vs expected RAM writes, and directed write/abort sequences.
module tb_ds1302_reader;
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    ds1302_reader_if bus();
    ds1302_reader #(.CLK_DIV(4), .REFRESH_N(20000)) dut (.clk(clk), .clr(clr), .bus(bus));

    typedef struct { logic [7:0] dev; logic [3:0] addr; logic [7:0] data; bit wr; } vec_t;
    typedef struct { logic [3:0] addr; logic [7:0] data; logic valid; } ram_t;
    typedef struct { logic [7:0] cmd; logic [7:0] wd; int len; int gap; } txn_t;

    vec_t        tab [2][8];
    ram_t        ram_q[$];
    txn_t        txn_q[$];
    logic [63:0] dev_word = '0;
    int checks = 0, failures = 0;
    int cyc = 0, rises = 0, fidx = 0, busy_cnt = 0, last_end = 0, start_gap = 0;
    int ack_cnt = 0, ack_pos = 0;
    logic [7:0] cap_cmd = '0, cap_wd = '0;
    logic oe_r8 = 1'b0, oe_a8 = 1'b1, chk_next = 1'b0;
    logic p_ce = 1'b0, p_sclk = 1'b0, p_busy = 1'b0;

    // DS1302 model plus bus monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (cyc == 0) bus.ds_io_in = 1'b0;
        cyc++;
        if (bus.ds_ce && !p_ce) begin
            rises = 0; fidx = 0; cap_cmd = '0; cap_wd = '0;
        end
        if (chk_next) begin
            oe_a8 = bus.ds_io_oe;
            chk_next = 1'b0;
        end
        if (bus.ds_sclk && !p_sclk) begin
            if (rises < 8)       cap_cmd[rises[2:0]] = bus.ds_io_out;
            else if (rises < 16) cap_wd[rises[2:0]]  = bus.ds_io_out;
            if (rises == 7) begin
                oe_r8 = bus.ds_io_oe;
                chk_next = 1'b1;
            end
            rises++;
        end
        if (!bus.ds_sclk && p_sclk && rises >= 8 && cap_cmd[0] && fidx < 64) begin
            bus.ds_io_in = dev_word[fidx[5:0]];
            fidx++;
        end
        if (bus.ram_we) ram_q.push_back('{bus.ram_waddr, bus.ram_wdata, bus.valid});
        if (bus.busy && !p_busy) begin
            busy_cnt = 0;
            start_gap = cyc - last_end;
        end
        if (bus.busy) busy_cnt++;
        if (bus.wr_ack) begin
            ack_cnt++;
            ack_pos = busy_cnt;
        end
        if (!bus.busy && p_busy) begin
            txn_q.push_back('{cap_cmd, cap_wd, busy_cnt, start_gap});
            last_end = cyc;
        end
        p_ce = bus.ds_ce; p_sclk = bus.ds_sclk; p_busy = bus.busy;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic expire(input string what);
        checks++;
        failures++;
        $display("FAIL timeout_%s actual=expired required=event", what);
    endtask

    task automatic wait_txns(input int n);
        int b = 0;
        while (txn_q.size() < n && b < 3000) begin
            @(negedge clk);
            b++;
        end
        if (txn_q.size() < n) expire("txn");
    endtask

    task automatic wait_ack();
        int b = 0;
        bit seen = 1'b0;
        while (!seen && b < 3000) begin
            @(negedge clk);
            seen = bus.wr_ack;
            b++;
        end
        if (!seen) expire("wr_ack");
    endtask

    function automatic logic [63:0] word_of(input int s);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = tab[s][k].dev;
        return w;
    endfunction

    task automatic check_ram(input int base, input int s, input bit fresh);
        int idx = base;
        for (int k = 0; k < 8; k++) begin
            if (tab[s][k].wr) begin
                chk($sformatf("ram%0d_byte%0d_addr", s, k), 32'(ram_q[idx].addr), 32'(tab[s][k].addr));
                chk($sformatf("ram%0d_byte%0d_data", s, k), 32'(ram_q[idx].data), 32'(tab[s][k].data));
                chk($sformatf("ram%0d_byte%0d_valid", s, k), 32'(ram_q[idx].valid),
                    fresh ? 32'(k == 6) : 32'd1);
                idx++;
            end
        end
        chk("ram_count", ram_q.size() - base, 7);
    endtask

    initial begin
        int nt, rb, a0, pre, b;
        tab[0][0] = '{8'h85, 4'd0, 8'h05, 1'b1};
        tab[0][1] = '{8'h59, 4'd1, 8'h59, 1'b1};
        tab[0][2] = '{8'h23, 4'd2, 8'h23, 1'b1};
        tab[0][3] = '{8'h31, 4'd4, 8'h31, 1'b1};
        tab[0][4] = '{8'h12, 4'd5, 8'h12, 1'b1};
        tab[0][5] = '{8'h07, 4'd3, 8'h07, 1'b1};
        tab[0][6] = '{8'h99, 4'd6, 8'h99, 1'b1};
        tab[0][7] = '{8'h80, 4'd7, 8'h00, 1'b0};
        tab[1][0] = '{8'hD9, 4'd0, 8'h59, 1'b1};
        tab[1][1] = '{8'h07, 4'd1, 8'h07, 1'b1};
        tab[1][2] = '{8'hE2, 4'd2, 8'h22, 1'b1};
        tab[1][3] = '{8'h28, 4'd4, 8'h28, 1'b1};
        tab[1][4] = '{8'h02, 4'd5, 8'h02, 1'b1};
        tab[1][5] = '{8'h01, 4'd3, 8'h01, 1'b1};
        tab[1][6] = '{8'h24, 4'd6, 8'h24, 1'b1};
        tab[1][7] = '{8'h00, 4'd7, 8'h00, 1'b0};

        bus.refresh = 1'b0; bus.wr_req = 1'b0; bus.wr_reg = 3'd0; bus.wr_data = 8'h00;
        dev_word = word_of(0);
        clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ce", 32'(bus.ds_ce), 0);
        chk("rst_sclk", 32'(bus.ds_sclk), 0);
        chk("rst_oe", 32'(bus.ds_io_oe), 0);
        chk("rst_io_out", 32'(bus.ds_io_out), 0);
        chk("rst_ram_we", 32'(bus.ram_we), 0);
        chk("rst_waddr", 32'(bus.ram_waddr), 0);
        chk("rst_wdata", 32'(bus.ram_wdata), 0);
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_wr_ack", 32'(bus.wr_ack), 0);
        @(posedge clk) #1 clr = 1'b0;

        // first burst read after reset
`ifdef DS1302_UNPROTECT_EN
        wait_txns(1);
        chk("unprot_cmd", 32'(txn_q[0].cmd), 32'h8E);
        chk("unprot_data", 32'(txn_q[0].wd), 32'h00);
        chk("unprot_no_ack", ack_cnt, 0);
        nt = 2;
`else
        nt = 1;
`endif
        wait_txns(nt);
        chk("rd_cmd", 32'(txn_q[nt-1].cmd), 32'hBF);
        chk("rd_len", txn_q[nt-1].len, 584);
        chk("rd_oe_at_rise8", 32'(oe_r8), 1);
        chk("rd_oe_after_rise8", 32'(oe_a8), 0);
        check_ram(0, 0, 1'b1);
        chk("valid_after_read", 32'(bus.valid), 1);

        // single register write
        rb = ram_q.size(); nt = txn_q.size(); a0 = ack_cnt;
        repeat (5) @(posedge clk);
        #1 bus.wr_reg = 3'd2; bus.wr_data = 8'h14; bus.wr_req = 1'b1;
        wait_ack();
        @(posedge clk) #1 bus.wr_req = 1'b0;
        wait_txns(nt + 1);
        chk("wr_cmd", 32'(txn_q[nt].cmd), 32'h84);
        chk("wr_data", 32'(txn_q[nt].wd), 32'h14);
        chk("wr_len", txn_q[nt].len, 136);
        chk("wr_ack_pos", ack_pos, 136);
        chk("wr_ack_once", ack_cnt - a0, 1);
        chk("wr_no_ram_we", ram_q.size() - rb, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("idle_after_write", 32'(bus.busy), 0);

        // write and refresh in the same idle cycle
        rb = ram_q.size(); nt = txn_q.size(); a0 = ack_cnt;
        dev_word = word_of(1);
        @(posedge clk) #1 bus.wr_reg = 3'd5; bus.wr_data = 8'hA7; bus.wr_req = 1'b1; bus.refresh = 1'b1;
        @(posedge clk) #1 bus.refresh = 1'b0;
        wait_ack();
        @(posedge clk) #1 bus.wr_req = 1'b0;
        wait_txns(nt + 2);
        chk("both_first_cmd", 32'(txn_q[nt].cmd), 32'h8A);
        chk("both_first_data", 32'(txn_q[nt].wd), 32'hA7);
        chk("both_second_cmd", 32'(txn_q[nt+1].cmd), 32'hBF);
        chk("both_read_gap", txn_q[nt+1].gap, 1);
        chk("both_read_len", txn_q[nt+1].len, 584);
        chk("both_ack_once", ack_cnt - a0, 1);
        check_ram(rb, 1, 1'b0);

        // clr in the middle of a burst read
        dev_word = word_of(0);
        rb = ram_q.size(); a0 = ack_cnt;
        @(posedge clk) #1 bus.refresh = 1'b1;
        @(posedge clk) #1 bus.refresh = 1'b0;
        b = 0;
        while (!(rises == 30 && bus.ds_sclk) && b < 3000) begin
            @(negedge clk);
            b++;
        end
        if (b >= 3000) expire("rise30");
        clr = 1'b1;
        pre = ram_q.size();
        @(posedge clk) #1 clr = 1'b0;
        @(negedge clk);
        chk("abort_ce", 32'(bus.ds_ce), 0);
        chk("abort_sclk", 32'(bus.ds_sclk), 0);
        chk("abort_oe", 32'(bus.ds_io_oe), 0);
        chk("abort_valid", 32'(bus.valid), 0);
        chk("abort_bytes_before", pre - rb, 2);
        @(negedge clk);
        nt = txn_q.size();
`ifdef DS1302_UNPROTECT_EN
        wait_txns(nt + 2);
        chk("abort_unprot_cmd", 32'(txn_q[nt].cmd), 32'h8E);
        chk("abort_unprot_no_ack", ack_cnt - a0, 0);
        nt = nt + 1;
`else
        wait_txns(nt + 1);
`endif
        chk("abort_reread_cmd", 32'(txn_q[nt].cmd), 32'hBF);
        chk("abort_reread_len", txn_q[nt].len, 584);
        check_ram(pre, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ds1302_reader.md
# ds1302_reader

Serial front end between the DS1302 real-time clock chip and the display RAM that the display scanner reads. It periodically burst-reads the eight DS1302 clock registers over the 3-wire interface and writes the BCD bytes into the display RAM at the slots the scanner expects. It also performs single-register writes requested by the time-setting logic.

## Interface
Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles (≥1).
- REFRESH_N, 1000: clk cycles between automatic burst-read starts.

Ports:
- clk  in  1  system clock; one clock domain.
- clr  in  1  reset, synchronous, active-high.
- refresh  in  1  one-cycle pulse; requests an immediate burst read.
- wr_req  in  1  write request; held high until wr_ack.
- wr_reg  in  3  DS1302 clock register index 0..7.
- wr_data  in  8  byte to write.
- wr_ack  out  1  one-cycle pulse when the write transaction completes.
- busy  out  1  serial transaction in progress.
- valid  out  1  at least one burst read has completed since reset.
- ram_waddr  out  4  display RAM write address.
- ram_wdata  out  8  display RAM write data.
- ram_we  out  1  display RAM write strobe, one cycle per byte.
- ds_ce  out  1  DS1302 CE.
- ds_sclk  out  1  DS1302 SCLK.
- ds_io_out  out  1  IO drive value.
- ds_io_oe  out  1  IO drive enable; the top-level pad is tri-stated when low.
- ds_io_in  in  1  IO pad input.

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD.
  - IDLE: ce=0, sclk=0, oe=0. If a write is pending, start a write. Otherwise, if a read is pending, start a read. Otherwise stay.
  - SETUP: ce=1, sclk=0, for CLK_DIV cycles.
  - SHIFT: bit loop. Each bit is CLK_DIV cycles with sclk low, then CLK_DIV cycles with sclk high.
  - HOLD: ce=0, sclk=0, oe=0, for CLK_DIV cycles, then return to IDLE.
- Command byte, shifted LSB first:
  - Burst read: 0xBF.
  - Write: 0x80 | (wr_reg<<1).
- During command bits and write data bits: oe=1, and io_out changes only at the start of each sclk-low phase.
- Read data: oe=0 from the first cycle after the 8th command rising edge. 64 data bits follow (8 bytes, LSB first). io_in is sampled in the last clk cycle of each sclk-low phase.
- Write data: 8 bits of wr_data, LSB first. wr_reg and wr_data are latched at transaction start.
- RAM mapping for burst byte k:
  - 0 sec → addr 0, data & 0x7F (CH bit stripped).
  - 1 min → addr 1.
  - 2 hour → addr 2, data & 0x3F (24-hour mode).
  - 3 date → addr 4.
  - 4 month → addr 5.
  - 5 day → addr 3.
  - 6 year → addr 6.
  - 7 WP → not written.
- Pending flags:
  - read_pend is set by a refresh pulse, by refresh timer expiry, or by reset release. It is cleared when a read starts.
  - write_pend follows wr_req and is cleared when wr_ack pulses.
  - Requests arriving while busy remain pending. A write beats a read at IDLE.
- Refresh timer: reloads to REFRESH_N-1 at each read start and decrements every cycle, saturating at 0. At 0 it sets read_pend.
- valid is set in the cycle of the byte-6 ram_we and stays set until reset.

## Timing
- Reset values:
  - State IDLE, ce=0, sclk=0, io_out=0, oe=0.
  - ram_we=0, ram_waddr=0, ram_wdata=0.
  - wr_ack=0, busy=0, valid=0.
  - Timer = 0, read_pend=1, write_pend=0.
- clr during any state forces the reset values on the next edge. Outputs are registered, so the pins drop one cycle after clr is sampled. A partial burst produces no further ram_we.
- busy goes high in the cycle after the start decision and stays high through the last HOLD cycle.
- Read transaction length: CLK_DIV·(2 + 144) cycles; 584 cycles for CLK_DIV=4.
- Write transaction length: CLK_DIV·(2 + 32) cycles; 136 cycles for CLK_DIV=4.
- ram_we pulses one cycle after the 8th bit of each byte is sampled. Bytes land in ascending k order, one pulse each.
- wr_ack pulses in the last HOLD cycle.
- Earliest next start is the cycle after HOLD ends.

## Configuration
- DS1302_UNPROTECT_EN defined: after each reset release, the block performs one internal write of 0x00 to register 7 (command 0x8E) before the first read. wr_ack does not pulse for this write. User writes pending at that time wait behind it.
- DS1302_UNPROTECT_EN undefined: the first transaction after reset is a burst read.

## Test plan
- Reset, then the device model returns bytes 0x85,0x59,0x23,0x31,0x12,0x07,0x99,0x80. Required RAM writes: addr0=0x05, addr1=0x59, addr2=0x23, addr4=0x31, addr5=0x12, addr3=0x07, addr6=0x99. No write to addr7. valid=1 after the addr6 write.
- Capture io_out at each sclk rising edge during the command phase: must read 0xBF LSB first. oe=0 after the 8th rising edge. Total busy length 584 cycles with CLK_DIV=4.
- wr_req with wr_reg=2, wr_data=0x14. Model must see command 0x84 then data 0x14. wr_ack pulses once, 136 cycles after busy rises. No ram_we.
- wr_req and refresh asserted in the same IDLE cycle: the write transaction runs first, then the burst read starts on the cycle after its HOLD ends.
- clr pulsed at the 30th sclk rising edge of a read: next cycle ce=0, sclk=0, oe=0, with no ram_we afterwards. A fresh read starts after clr deasserts.
- With DS1302_UNPROTECT_EN: the first transaction after reset is 0x8E/0x00 with no wr_ack, followed by the burst read.
